decode_stage_pipe: RTL and testbench

- Parametrised decode stage for the in-order RISC-V pipeline, with a built-in ID/EX pipeline register.
- Decodes the fetched instruction, reads the integer register file and generates the full sign-extended immediate.
- Detects load-use hazards against the instruction it holds for EX and inserts bubbles.
- Sits between fetch and execute; valid/ready handshake on both sides, plus flush.

---
 rtl/riscv_decode_pkg.sv | 54 +++++
 rtl/imm_gen.sv | 31 +++
 rtl/decode_stage_pipe.sv | 238 +++++++++++++++++++++++
 tb/tb_decode_stage_pipe.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_decode_pkg.sv
// Shared decode definitions: RV32 base opcodes, load/store width encodings,
// immediate formats and the packed control bundle carried through ID/EX.
package riscv_decode_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        LdByte  = 3'd0,
        LdHalf  = 3'd1,
        LdWord  = 3'd2,
        LdByteU = 3'd4,
        LdHalfU = 3'd5
    } load_type_e;

    typedef enum logic [1:0] {
        StByte = 2'd0,
        StHalf = 2'd1,
        StWord = 2'd2
    } store_type_e;

    typedef enum logic [2:0] {ImmNone, ImmI, ImmS, ImmB, ImmU, ImmJ} imm_fmt_e;

    typedef struct packed {
        logic       alu_src;
        logic       mem_write;
        logic [2:0] mem_load_type;
        logic [1:0] mem_store_type;
        logic       wb_load;
        logic       wb_reg_file;
        logic       illegal;
    } ctrl_t;

    function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
        imm_fmt_e fmt;
        case (opcode)
            OP_IMM, LOAD, JALR: fmt = ImmI;
            STORE:              fmt = ImmS;
            BRANCH:             fmt = ImmB;
            LUI, AUIPC:         fmt = ImmU;
            JAL:                fmt = ImmJ;
            default:            fmt = ImmNone;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: selects the I/S/B/U/J format from the
// opcode and sign-extends the result to XLEN.
module imm_gen
    import riscv_decode_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     inst_i,
    output logic [XLEN-1:0] imm_o
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (imm_fmt(inst_i[6:0]))
            ImmI: imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            ImmS: imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            ImmB: imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                           inst_i[11:8], 1'b0};
            ImmU: imm32 = {inst_i[31:12], 12'b0};
            ImmJ: imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                           inst_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Signed cast also sign-extends U-type when XLEN > 32.
    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage_pipe.sv
// RISC-V decode stage with register file, load-use hazard detection and the
// ID/EX pipeline register. DECODE_WB_BYPASS_EN enables write-through operand reads.
module decode_stage_pipe
    import riscv_decode_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NUM_REGS   = 32,
    parameter bit          RESET_REGS = 1'b1,
    localparam int unsigned REG_AW    = $clog2(NUM_REGS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       instruction_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [XLEN-1:0]   out_pc_o,
    output logic [XLEN-1:0]   op1_o,
    output logic [XLEN-1:0]   op2_o,
    output logic [REG_AW-1:0] rs1_o,
    output logic [REG_AW-1:0] rs2_o,
    output logic [REG_AW-1:0] rd_o,
    output logic [XLEN-1:0]   imm_o,
    output logic [6:0]        opcode_o,
    output logic [2:0]        func3_o,
    output logic [6:0]        func7_o,
    output logic              alu_src_o,
    output logic              mem_write_o,
    output logic [2:0]        mem_load_type_o,
    output logic [1:0]        mem_store_type_o,
    output logic              wb_load_o,
    output logic              wb_reg_file_o,
    output logic              illegal_o,
    input  logic              reg_file_wr_en_i,
    input  logic [REG_AW-1:0] reg_file_wr_addr_i,
    input  logic [XLEN-1:0]   reg_file_wr_data_i
);

    logic [6:0]        opc;
    logic [2:0]        f3;
    logic [REG_AW-1:0] rs1_in, rs2_in, rd_in;
    logic [XLEN-1:0]   imm_in;
    logic [XLEN-1:0]   rdata1, rdata2;
    ctrl_t             ctrl_in;
    logic              uses_rs1, uses_rs2;
    logic              adv, haz, in_ready, accept, wr_hit;

    assign opc    = instruction_i[6:0];
    assign f3     = instruction_i[14:12];
    assign rd_in  = instruction_i[7 +: REG_AW];
    assign rs1_in = instruction_i[15 +: REG_AW];
    assign rs2_in = instruction_i[20 +: REG_AW];

    imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .inst_i (instruction_i),
        .imm_o  (imm_in)
    );

    always_comb begin
        ctrl_in  = '0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opc)
            OP: begin
                uses_rs1            = 1'b1;
                uses_rs2            = 1'b1;
                ctrl_in.wb_reg_file = 1'b1;
            end
            OP_IMM: begin
                uses_rs1            = 1'b1;
                ctrl_in.alu_src     = 1'b1;
                ctrl_in.wb_reg_file = 1'b1;
            end
            LOAD: begin
                uses_rs1              = 1'b1;
                ctrl_in.alu_src       = 1'b1;
                ctrl_in.mem_load_type = f3;
                ctrl_in.wb_load       = 1'b1;
                ctrl_in.wb_reg_file   = 1'b1;
            end
            STORE: begin
                uses_rs1               = 1'b1;
                uses_rs2               = 1'b1;
                ctrl_in.alu_src        = 1'b1;
                ctrl_in.mem_write      = 1'b1;
                ctrl_in.mem_store_type = f3[1:0];
            end
            BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            JAL: ctrl_in.wb_reg_file = 1'b1;
            JALR: begin
                uses_rs1            = 1'b1;
                ctrl_in.alu_src     = 1'b1;
                ctrl_in.wb_reg_file = 1'b1;
            end
            LUI, AUIPC: begin
                ctrl_in.alu_src     = 1'b1;
                ctrl_in.wb_reg_file = 1'b1;
            end
            default: ctrl_in.illegal = 1'b1;
        endcase
    end

    // Register file: x0 is never written and always reads as zero.
    logic [XLEN-1:0] rf_q [NUM_REGS];

    assign wr_hit = reg_file_wr_en_i && (reg_file_wr_addr_i != '0);

    if (RESET_REGS) begin : g_rf_reset
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
            end else if (wr_hit) begin
                rf_q[reg_file_wr_addr_i] <= reg_file_wr_data_i;
            end
        end
    end else begin : g_rf_noreset
        always_ff @(posedge clk_i) begin
            if (wr_hit) rf_q[reg_file_wr_addr_i] <= reg_file_wr_data_i;
        end
    end

    always_comb begin
        rdata1 = (rs1_in == '0) ? '0 : rf_q[rs1_in];
        rdata2 = (rs2_in == '0) ? '0 : rf_q[rs2_in];
`ifdef DECODE_WB_BYPASS_EN
        if (wr_hit && (reg_file_wr_addr_i == rs1_in)) rdata1 = reg_file_wr_data_i;
        if (wr_hit && (reg_file_wr_addr_i == rs2_in)) rdata2 = reg_file_wr_data_i;
`endif
    end

    // ID/EX pipeline register.
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_q, pc_d, op1_q, op1_d, op2_q, op2_d, imm_q, imm_d;
    logic [REG_AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [6:0]        opcode_q, opcode_d, func7_q, func7_d;
    logic [2:0]        func3_q, func3_d;
    ctrl_t             ctrl_q, ctrl_d;

    assign adv = !valid_q || out_ready_i;
    assign haz = in_valid_i && valid_q && ctrl_q.wb_load && (rd_q != '0) &&
                 (((rd_q == rs1_in) && uses_rs1) || ((rd_q == rs2_in) && uses_rs2));
    assign in_ready = adv && !haz && !flush_i;
    assign accept   = in_valid_i && in_ready;

    always_comb begin
        valid_d  = valid_q;
        pc_d     = pc_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        imm_d    = imm_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        rd_d     = rd_q;
        opcode_d = opcode_q;
        func3_d  = func3_q;
        func7_d  = func7_q;
        ctrl_d   = ctrl_q;
        // Flush never accepts (in_ready is low), so it always lands on the bubble path.
        if (adv || flush_i) begin
            if (accept) begin
                valid_d  = 1'b1;
                pc_d     = pc_i;
                op1_d    = rdata1;
                op2_d    = rdata2;
                imm_d    = imm_in;
                rs1_d    = rs1_in;
                rs2_d    = rs2_in;
                rd_d     = rd_in;
                opcode_d = opc;
                func3_d  = f3;
                func7_d  = instruction_i[31:25];
                ctrl_d   = ctrl_in;
            end else begin
                valid_d = 1'b0;
                ctrl_d  = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            imm_q    <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            opcode_q <= '0;
            func3_q  <= '0;
            func7_q  <= '0;
            ctrl_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            imm_q    <= imm_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            opcode_q <= opcode_d;
            func3_q  <= func3_d;
            func7_q  <= func7_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign in_ready_o       = in_ready;
    assign out_valid_o      = valid_q;
    assign out_pc_o         = pc_q;
    assign op1_o            = op1_q;
    assign op2_o            = op2_q;
    assign imm_o            = imm_q;
    assign rs1_o            = rs1_q;
    assign rs2_o            = rs2_q;
    assign rd_o             = rd_q;
    assign opcode_o         = opcode_q;
    assign func3_o          = func3_q;
    assign func7_o          = func7_q;
    assign alu_src_o        = ctrl_q.alu_src;
    assign mem_write_o      = ctrl_q.mem_write;
    assign mem_load_type_o  = ctrl_q.mem_load_type;
    assign mem_store_type_o = ctrl_q.mem_store_type;
    assign wb_load_o        = ctrl_q.wb_load;
    assign wb_reg_file_o    = ctrl_q.wb_reg_file;
    assign illegal_o        = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Scoreboard bench for decode_stage_pipe: directed instructions push hand-computed
// expectations; a monitor pops and compares on every out_valid & out_ready.
module tb_decode_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] instruction, pc, out_pc, op1, op2, imm;
    logic [4:0]  rs1, rs2, rd, wr_addr;
    logic [6:0]  opcode, func7;
    logic [2:0]  func3, mem_load_type;
    logic [1:0]  mem_store_type;
    logic        alu_src, mem_write, wb_load, wb_reg_file, illegal, wr_en;
    logic [31:0] wr_data;

    always #5 clk = ~clk;

    decode_stage_pipe #(
        .XLEN       (32),
        .NUM_REGS   (32),
        .RESET_REGS (1'b1)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .in_valid_i         (in_valid),
        .in_ready_o         (in_ready),
        .instruction_i      (instruction),
        .pc_i               (pc),
        .flush_i            (flush),
        .out_valid_o        (out_valid),
        .out_ready_i        (out_ready),
        .out_pc_o           (out_pc),
        .op1_o              (op1),
        .op2_o              (op2),
        .rs1_o              (rs1),
        .rs2_o              (rs2),
        .rd_o               (rd),
        .imm_o              (imm),
        .opcode_o           (opcode),
        .func3_o            (func3),
        .func7_o            (func7),
        .alu_src_o          (alu_src),
        .mem_write_o        (mem_write),
        .mem_load_type_o    (mem_load_type),
        .mem_store_type_o   (mem_store_type),
        .wb_load_o          (wb_load),
        .wb_reg_file_o      (wb_reg_file),
        .illegal_o          (illegal),
        .reg_file_wr_en_i   (wr_en),
        .reg_file_wr_addr_i (wr_addr),
        .reg_file_wr_data_i (wr_data)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] imm;
        logic [9:0]  ctl;  // {alu_src, mem_write, load_type[2:0], store_type[1:0], wb_load, wb_reg, illegal}
        logic        chk_ops;
        logic [31:0] op1;
        logic [31:0] op2;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] p, input logic [31:0] inst,
                                input logic [31:0] im, input logic [9:0] ctl,
                                input logic chk, input logic [31:0] o1, input logic [31:0] o2);
        exp_t e;
        e.pc = p; e.inst = inst; e.imm = im; e.ctl = ctl;
        e.chk_ops = chk; e.op1 = o1; e.op2 = o2;
        return e;
    endfunction

    // Monitor: compares every transfer from ID/EX to execute.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_ni && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("out_pc", out_pc, mon_e.pc);
                    check("opcode", 32'(opcode), 32'(mon_e.inst[6:0]));
                    check("rd", 32'(rd), 32'(mon_e.inst[11:7]));
                    check("func3", 32'(func3), 32'(mon_e.inst[14:12]));
                    check("rs1", 32'(rs1), 32'(mon_e.inst[19:15]));
                    check("rs2", 32'(rs2), 32'(mon_e.inst[24:20]));
                    check("func7", 32'(func7), 32'(mon_e.inst[31:25]));
                    check("imm", imm, mon_e.imm);
                    check("ctrl", 32'({alu_src, mem_write, mem_load_type, mem_store_type,
                                       wb_load, wb_reg_file, illegal}), 32'(mon_e.ctl));
                    if (mon_e.chk_ops) begin
                        check("op1", op1, mon_e.op1);
                        check("op2", op2, mon_e.op2);
                    end
                end
            end
        end
    end

    // Presents one instruction (with an optional concurrent writeback) until accepted.
    task automatic issue(input logic [31:0] inst, input logic [31:0] p, input logic push,
                         input exp_t e, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd);
        logic acc;
        instruction = inst; pc = p; in_valid = 1'b1;
        wr_en = we; wr_addr = wa; wr_data = wd;
        acc = 1'b0;
        for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                if (push) sb_q.push_back(e);
            end
            @(posedge clk); #1;
        end
        if (!acc) check("accept_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0; wr_en = 1'b0;
    endtask

    task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    exp_t        none;
    logic [31:0] byp_op1;

    initial begin
        none = '0;
        rst_ni = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        instruction = '0; pc = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_imm", imm, 32'd0);
        check("rst_ctrl", 32'({alu_src, mem_write, wb_load, wb_reg_file, illegal}), 32'd0);
        rst_ni = 1'b1;
        idle(1);

        rf_write(5'd1, 32'h0000_1234);
        rf_write(5'd2, 32'h0000_0100);
        rf_write(5'd4, 32'h0000_0004);
        rf_write(5'd7, 32'h1111_1111);

        // ADDI x5,x0,-1
        issue(32'hFFF00293, 32'h1000, 1'b1,
              mk(32'h1000, 32'hFFF00293, 32'hFFFF_FFFF, 10'b1_0_000_00_0_1_0, 1'b1, 0, 0),
              1'b0, 5'd0, 32'd0);
        // LW x1,0(x2)
        issue(32'h00012083, 32'h1004, 1'b1,
              mk(32'h1004, 32'h00012083, 32'h0, 10'b1_0_010_00_1_1_0, 1'b1, 32'h100, 0),
              1'b0, 5'd0, 32'd0);
        // ADD x3,x1,x4 right behind the load: one bubble, then it issues
        instruction = 32'h004081B3; pc = 32'h1008; in_valid = 1'b1;
        @(negedge clk);
        check("haz_in_ready", 32'(in_ready), 32'd0);
        check("haz_load_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("bubble_valid", 32'(out_valid), 32'd0);
        check("post_bubble_ready", 32'(in_ready), 32'd1);
        sb_q.push_back(mk(32'h1008, 32'h004081B3, 32'h0, 10'b0_0_000_00_0_1_0, 1'b1,
                          32'h1234, 32'h4));
        @(posedge clk); #1;
        in_valid = 1'b0;
        idle(1);

        // BEQ x1,x2,+8 held for 3 cycles, then flushed while still stalled
        out_ready = 1'b0;
        issue(32'h00208463, 32'h1010, 1'b0, none, 1'b0, 5'd0, 32'd0);
        instruction = 32'h00000013; pc = 32'h1014; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_imm", imm, 32'd8);
            check("stall_opcode", 32'(opcode), 32'h63);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_ctrl", 32'({alu_src, wb_reg_file, illegal}), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;

        // ADD x8,x7,x0 while x7 <= 0xDEADBEEF is written back
`ifdef DECODE_WB_BYPASS_EN
        byp_op1 = 32'hDEAD_BEEF;
`else
        byp_op1 = 32'h1111_1111;
`endif
        issue(32'h00038433, 32'h2000, 1'b1,
              mk(32'h2000, 32'h00038433, 32'h0, 10'b0_0_000_00_0_1_0, 1'b1, byp_op1, 0),
              1'b1, 5'd7, 32'hDEAD_BEEF);
        // ADD x8,x0,x7 while x0 is written: x0 still reads zero
        issue(32'h00700433, 32'h2004, 1'b1,
              mk(32'h2004, 32'h00700433, 32'h0, 10'b0_0_000_00_0_1_0, 1'b1, 0, 32'hDEAD_BEEF),
              1'b1, 5'd0, 32'h5555_5555);
        // JAL x1,-4
        issue(32'hFFDFF0EF, 32'h2008, 1'b1,
              mk(32'h2008, 32'hFFDFF0EF, 32'hFFFF_FFFC, 10'b0_0_000_00_0_1_0, 1'b0, 0, 0),
              1'b0, 5'd0, 32'd0);
        // Opcode 0x7F is not a recognised opcode
        issue(32'h0000057F, 32'h200C, 1'b1,
              mk(32'h200C, 32'h0000057F, 32'h0, 10'b0_0_000_00_0_0_1, 1'b1, 0, 0),
              1'b0, 5'd0, 32'd0);
        // SW x4,12(x2)
        issue(32'h00412623, 32'h2010, 1'b1,
              mk(32'h2010, 32'h00412623, 32'd12, 10'b1_1_000_10_0_0_0, 1'b1, 32'h100, 32'h4),
              1'b0, 5'd0, 32'd0);
        // LUI x9,0x80000
        issue(32'h800004B7, 32'h2014, 1'b1,
              mk(32'h2014, 32'h800004B7, 32'h8000_0000, 10'b1_0_000_00_0_1_0, 1'b1, 0, 0),
              1'b0, 5'd0, 32'd0);
        idle(2);

        // Asynchronous reset while an instruction is stalled in ID/EX
        out_ready = 1'b0;
        issue(32'hFFF00293, 32'h3000, 1'b0, none, 1'b0, 5'd0, 32'd0);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_imm", imm, 32'd0);
        check("async_rst_ctrl", 32'({alu_src, wb_reg_file, wb_load, mem_write}), 32'd0);
        @(posedge clk); #1;
        rst_ni = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_valid", 32'(out_valid), 32'd0);
        idle(2);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
